// File: rtl/food_spawner_if.sv
// rtl/food_spawner_if.sv - body-occupancy query channel between the food spawner and the snake body
interface food_spawner_if #(
  parameter int COORD_W = 6
);
  logic               occ_req;
  logic [COORD_W-1:0] occ_x;
  logic [COORD_W-1:0] occ_y;
  logic               occ_hit;

  modport master (output occ_req, occ_x, occ_y, input occ_hit);
  modport slave  (input occ_req, occ_x, occ_y, output occ_hit);
endinterface

// File: rtl/food_spawner.sv
// rtl/food_spawner.sv - apple placement: eat detection, LFSR candidate draw, occupancy check, fallback
module food_spawner #(
  parameter int          GRID_W    = 40,
  parameter int          GRID_H    = 30,
  parameter int          COORD_W   = 6,
  parameter int          N_APPLES  = 2,
  parameter int          MAX_TRIES = 15,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                          clk_50MHz,
  input  logic                          rst_n,
  input  logic [1:0]                    mode,
  input  logic [COORD_W-1:0]            head_x,
  input  logic [COORD_W-1:0]            head_y,
  output logic [N_APPLES*COORD_W-1:0]   apple_x,
  output logic [N_APPLES*COORD_W-1:0]   apple_y,
  output logic [N_APPLES-1:0]           apple_valid,
  output logic                          eat,
  output logic [1:0]                    eat_idx,
  output logic                          busy,
  food_spawner_if.master                occ
);

  localparam int                 TRIES_W   = $clog2(MAX_TRIES + 1);
  localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_TRIES);
  localparam logic [TRIES_W-1:0] TRIES_ONE = TRIES_W'(1);
  localparam logic [15:0]        SEED_NZ   = (SEED == 16'd0) ? 16'd1 : SEED;
  localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(GRID_W - 2);
  localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(GRID_H - 2);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DRAW, S_WAIT} state_t;

  function automatic logic [COORD_W-1:0] def_x(input int i);
    return COORD_W'(GRID_W / 2 + 2 * i);
  endfunction

  function automatic logic [COORD_W-1:0] def_y(input int i);
    return COORD_W'(GRID_H / 2 + 0 * i);
  endfunction

  state_t               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [COORD_W-1:0]   ax_q [N_APPLES];
  logic [COORD_W-1:0]   ax_d [N_APPLES];
  logic [COORD_W-1:0]   ay_q [N_APPLES];
  logic [COORD_W-1:0]   ay_d [N_APPLES];
  logic [N_APPLES-1:0]  valid_q, valid_d;
  logic [N_APPLES-1:0]  pending_q, pending_d;
  logic [1:0]           target_q, target_d;
  logic [TRIES_W-1:0]   tries_q, tries_d;
  logic                 eat_q, eat_d;
  logic [1:0]           eat_idx_q, eat_idx_d;
  logic                 occ_req_q, occ_req_d;
  logic [COORD_W-1:0]   occ_x_q, occ_x_d;
  logic [COORD_W-1:0]   occ_y_q, occ_y_d;

  logic [COORD_W-1:0]   cand_x, cand_y;
  logic                 cand_bad;
  logic                 eat_any;
  logic [1:0]           eat_sel;
  logic [1:0]           low_pend;
  logic                 commit, commit_def;
  logic [COORD_W-1:0]   commit_x, commit_y;
  logic [TRIES_W-1:0]   tries_inc;

  assign cand_x    = lfsr_q[COORD_W-1:0];
  assign cand_y    = lfsr_q[2*COORD_W-1:COORD_W];
  assign tries_inc = (tries_q >= TRIES_MAX) ? tries_q : tries_q + TRIES_ONE;

  always_comb begin
    eat_any  = 1'b0;
    eat_sel  = 2'd0;
    low_pend = 2'd0;
    cand_bad = (cand_x == '0) || (cand_x > X_MAX) || (cand_y == '0) || (cand_y > Y_MAX) ||
               ((cand_x == head_x) && (cand_y == head_y));
    for (int i = 0; i < N_APPLES; i++) begin
      if (valid_q[i] && (ax_q[i] == head_x) && (ay_q[i] == head_y)) begin
        eat_any = 1'b1;
        eat_sel = 2'(i);
      end
      if (valid_q[i] && (ax_q[i] == cand_x) && (ay_q[i] == cand_y)) cand_bad = 1'b1;
    end
    for (int i = N_APPLES - 1; i >= 0; i--) begin
      if (pending_q[i]) low_pend = 2'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    ax_d       = ax_q;
    ay_d       = ay_q;
    valid_d    = valid_q;
    pending_d  = pending_q;
    target_d   = target_q;
    tries_d    = tries_q;
    eat_d      = 1'b0;
    eat_idx_d  = eat_idx_q;
    occ_req_d  = 1'b0;
    occ_x_d    = occ_x_q;
    occ_y_d    = occ_y_q;
    commit     = 1'b0;
    commit_def = 1'b0;
    commit_x   = occ_x_q;
    commit_y   = occ_y_q;

    // Leaving play mode or sitting in IDLE discards any respawn and restores defaults.
    if ((mode != 2'd1) || (state_q == S_IDLE)) begin
      state_d   = (mode == 2'd1) ? S_PLAY : S_IDLE;
      valid_d   = '1;
      pending_d = '0;
      target_d  = 2'd0;
      tries_d   = '0;
      occ_x_d   = '0;
      occ_y_d   = '0;
      for (int i = 0; i < N_APPLES; i++) begin
        ax_d[i] = def_x(i);
        ay_d[i] = def_y(i);
      end
    end else begin
      unique case (state_q)
        S_PLAY: begin
          if (|pending_q) begin
            target_d = low_pend;
            tries_d  = '0;
            state_d  = S_DRAW;
          end
        end
        S_DRAW: begin
          if (tries_q >= TRIES_MAX) begin
            commit     = 1'b1;
            commit_def = 1'b1;
          end else if (cand_bad) begin
            tries_d = tries_inc;
          end else begin
            occ_req_d = 1'b1;
            occ_x_d   = cand_x;
            occ_y_d   = cand_y;
            state_d   = S_WAIT;
          end
        end
        S_WAIT: begin
          if (tries_q >= TRIES_MAX) begin
            commit     = 1'b1;
            commit_def = 1'b1;
          end else if (occ.occ_hit) begin
            tries_d = tries_inc;
            state_d = S_DRAW;
          end else begin
            commit = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (commit) begin
        state_d = S_PLAY;
        for (int i = 0; i < N_APPLES; i++) begin
          if (target_q == 2'(i)) begin
            ax_d[i]      = commit_def ? def_x(i) : commit_x;
            ay_d[i]      = commit_def ? def_y(i) : commit_y;
            valid_d[i]   = 1'b1;
            pending_d[i] = 1'b0;
          end
        end
      end

      // The target is never valid, so an eat here can never collide with the commit above.
      if (eat_any) begin
        eat_d     = 1'b1;
        eat_idx_d = eat_sel;
        for (int i = 0; i < N_APPLES; i++) begin
          if (eat_sel == 2'(i)) begin
            valid_d[i]   = 1'b0;
            pending_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED_NZ;
      valid_q   <= '1;
      pending_q <= '0;
      target_q  <= 2'd0;
      tries_q   <= '0;
      eat_q     <= 1'b0;
      eat_idx_q <= 2'd0;
      occ_req_q <= 1'b0;
      occ_x_q   <= '0;
      occ_y_q   <= '0;
      for (int i = 0; i < N_APPLES; i++) begin
        ax_q[i] <= def_x(i);
        ay_q[i] <= def_y(i);
      end
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      tries_q   <= tries_d;
      eat_q     <= eat_d;
      eat_idx_q <= eat_idx_d;
      occ_req_q <= occ_req_d;
      occ_x_q   <= occ_x_d;
      occ_y_q   <= occ_y_d;
      ax_q      <= ax_d;
      ay_q      <= ay_d;
    end
  end

  always_comb begin
    apple_x = '0;
    apple_y = '0;
    for (int i = 0; i < N_APPLES; i++) begin
      apple_x[i*COORD_W +: COORD_W] = ax_q[i];
      apple_y[i*COORD_W +: COORD_W] = ay_q[i];
    end
  end

  assign apple_valid = valid_q;
  assign eat         = eat_q;
  assign eat_idx     = eat_idx_q;
  assign busy        = (state_q == S_DRAW) || (state_q == S_WAIT);
  assign occ.occ_req = occ_req_q;
  assign occ.occ_x   = occ_x_q;
  assign occ.occ_y   = occ_y_q;

endmodule

// File: tb/tb_food_spawner.sv
// tb/tb_food_spawner.sv - scoreboard bench for food_spawner: eat pulses and apple commits checked by a monitor
module tb_food_spawner;
  localparam int CW = 6;
  localparam int NA = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       mode;
  logic [CW-1:0]    head_x, head_y;
  logic [NA*CW-1:0] apple_x, apple_y;
  logic [NA-1:0]    apple_valid;
  logic             eat;
  logic [1:0]       eat_idx;
  logic             busy;

  food_spawner_if #(.COORD_W(CW)) occ_if ();

  food_spawner #(
    .GRID_W(40), .GRID_H(30), .COORD_W(CW), .N_APPLES(NA), .MAX_TRIES(15), .SEED(16'hACE1)
  ) dut (
    .clk_50MHz(clk), .rst_n(rst_n), .mode(mode), .head_x(head_x), .head_y(head_y),
    .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
    .eat(eat), .eat_idx(eat_idx), .busy(busy), .occ(occ_if.master)
  );

  always #10 clk = ~clk;

  typedef struct {
    int idx;
    bit is_def;
    int hx;
    int hy;
  } commit_t;

  int        checks   = 0;
  int        failures = 0;
  logic [1:0] eat_exp_q [$];
  commit_t   commit_q [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic int def_x(input int i);
    return 20 + 2 * i;
  endfunction

  // Scoreboard monitor: pops one expectation per eat pulse and per newly valid apple.
  logic [NA-1:0] prev_valid = '1;
  always @(negedge clk) begin : monitor
    commit_t c;
    logic [1:0] e;
    int ax, ay, ox, oy;
    bit ok;
    if (eat === 1'b1) begin
      if (eat_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_eat got_idx=%0d expected=no_eat", eat_idx);
      end else begin
        e = eat_exp_q.pop_front();
        check("eat_idx", 32'(eat_idx), 32'(e));
      end
    end
    for (int i = 0; i < NA; i++) begin
      if (apple_valid[i] && !prev_valid[i]) begin
        ax = int'(apple_x[i*CW +: CW]);
        ay = int'(apple_y[i*CW +: CW]);
        if (commit_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_commit got_idx=%0d expected=no_commit", i);
        end else begin
          c = commit_q.pop_front();
          check("commit_idx", 32'(i), 32'(c.idx));
          if (c.is_def) begin
            check("commit_def_x", 32'(ax), 32'(def_x(i)));
            check("commit_def_y", 32'(ay), 32'd15);
          end else begin
            check("commit_in_range", 32'(ax >= 1 && ax <= 38 && ay >= 1 && ay <= 28), 32'd1);
            check("commit_not_head", 32'(ax == c.hx && ay == c.hy), 32'd0);
            ok = 1'b1;
            for (int j = 0; j < NA; j++) begin
              ox = int'(apple_x[j*CW +: CW]);
              oy = int'(apple_y[j*CW +: CW]);
              if (j != i && apple_valid[j] && ox == ax && oy == ay) ok = 1'b0;
            end
            check("commit_not_other", 32'(ok), 32'd1);
          end
        end
      end
    end
    prev_valid <= apple_valid;
  end

  task automatic wait_valid_all(input string name, input int bound, output int cyc);
    cyc = 0;
    while (apple_valid !== 2'b11 && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    check(name, 32'(apple_valid), 32'd3);
  endtask

  task automatic push_commit(input int idx, input bit is_def, input int hx, input int hy);
    commit_t c;
    c.idx = idx; c.is_def = is_def; c.hx = hx; c.hy = hy;
    commit_q.push_back(c);
  endtask

  task automatic eat_at(input int x, input int y, input logic [1:0] idx);
    head_x = CW'(x);
    head_y = CW'(y);
    eat_exp_q.push_back(idx);
    @(negedge clk);
    head_x = CW'(1);
    head_y = CW'(1);
  endtask

  initial begin
    int cyc;
    bit got_wait;
    rst_n = 1'b0;
    mode = 2'd0;
    head_x = '0;
    head_y = '0;
    occ_if.occ_hit = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_apple_x", 32'(apple_x), 32'd1428);
    check("rst_apple_y", 32'(apple_y), 32'd975);
    check("rst_valid", 32'(apple_valid), 32'd3);
    check("rst_eat", 32'(eat), 32'd0);
    check("rst_eat_idx", 32'(eat_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_occ_req", 32'(occ_if.occ_req), 32'd0);
    check("rst_occ_xy", 32'({occ_if.occ_x, occ_if.occ_y}), 32'd0);

    rst_n = 1'b1;
    mode = 2'd1;
    repeat (3) @(negedge clk);
    check("play_busy", 32'(busy), 32'd0);

    // Eat apple 0 at its default cell, then let it respawn freely.
    head_x = CW'(20);
    head_y = CW'(15);
    eat_exp_q.push_back(2'd0);
    @(negedge clk);
    check("eat_valid_cleared", 32'(apple_valid), 32'd2);
    check("eat_cycle_busy", 32'(busy), 32'd0);
    head_x = CW'(1);
    head_y = CW'(1);
    push_commit(0, 1'b0, 1, 1);
    @(negedge clk);
    check("busy_after_eat", 32'(busy), 32'd1);
    wait_valid_all("random_commit_valid", 200, cyc);
    check("random_commit_busy", 32'(busy), 32'd0);

    // Every occupancy query hits: apple 0 must fall back to its default cell.
    occ_if.occ_hit = 1'b1;
    @(negedge clk);
    push_commit(0, 1'b1, 1, 1);
    eat_at(int'(apple_x[CW-1:0]), int'(apple_y[CW-1:0]), 2'd0);
    wait_valid_all("fallback_valid", 300, cyc);
    check("fallback_took_tries", 32'(cyc >= 15), 32'd1);

    // Second apple eaten while the first is still respawning.
    @(negedge clk);
    push_commit(0, 1'b1, 1, 1);
    eat_at(20, 15, 2'd0);
    cyc = 0;
    while (busy !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_before_second_eat", 32'(busy), 32'd1);
    push_commit(1, 1'b1, 1, 1);
    eat_at(22, 15, 2'd1);
    check("both_invalid", 32'(apple_valid), 32'd0);
    check("busy_during_second", 32'(busy), 32'd1);
    wait_valid_all("both_restored", 400, cyc);

    // Drop out of play mode while waiting for an occupancy answer.
    got_wait = 1'b0;
    for (int a = 0; a < 5 && !got_wait; a++) begin
      @(negedge clk);
      push_commit(0, 1'b1, 1, 1);
      eat_at(20, 15, 2'd0);
      cyc = 0;
      while (occ_if.occ_req !== 1'b1 && apple_valid !== 2'b11 && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      if (occ_if.occ_req === 1'b1) got_wait = 1'b1;
      else wait_valid_all("retry_restore", 100, cyc);
    end
    check("wait_state_reached", 32'(got_wait), 32'd1);
    mode = 2'd0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(apple_valid), 32'd3);
    check("idle_apple_x", 32'(apple_x), 32'd1428);
    check("idle_apple_y", 32'(apple_y), 32'd975);
    check("idle_occ_req", 32'(occ_if.occ_req), 32'd0);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a respawn abandons it.
    mode = 2'd1;
    repeat (2) @(negedge clk);
    push_commit(0, 1'b1, 1, 1);
    eat_at(20, 15, 2'd0);
    @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_valid", 32'(apple_valid), 32'd3);
    check("async_rst_apple_x", 32'(apple_x), 32'd1428);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    check("eat_queue_empty", 32'(eat_exp_q.size()), 32'd0);
    check("commit_queue_empty", 32'(commit_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
